mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencer for the binary-weight MAC in the VAD datapath.
- Per frame: clears the MAC, then streams N_ELEM 2-bit features from the feature buffer, LANES per cycle, into the MAC.
- Waits for mac_done, captures the two accumulator outputs and presents them downstream on a valid/ready handshake.
- Includes abort and a mac_done watchdog.

Parameters:
- N_ELEM, 108: feature elements per frame.
- LANES, 3: elements fed to the MAC per cycle. N_ELEM must be a multiple of LANES, so BEATS = N_ELEM/LANES = 36.
- DW, 2: bits per element.
- ADDR_W, 6: buffer address width, at least ceil(log2(BEATS)).
- ACC_W, 10: MAC output width per channel.
- WD_CYC, 16: maximum cycles to wait for mac_done.

Ports:
- clk  in  1  : single clock, rising edge.
- rst_n  in  1  : asynchronous active-low reset.
- start  in  1  : frame request, sampled only in IDLE.
- abort  in  1  : synchronous abort, any state.
- busy  out  1  : high whenever state != IDLE.
- rd_en  out  1  : feature buffer read strobe.
- rd_addr  out  ADDR_W  : beat address.
- rd_data  in  LANES*DW  : buffer data, valid 1 cycle after rd_en.
- mac_clr  out  1  : accumulator clear pulse.
- mac_vld  out  1  : mac_in valid.
- mac_in  out  LANES*DW  : lane data, lane0 in the LSBs.
- mac_out0  in  ACC_W  : MAC channel 1 result.
- mac_out1  in  ACC_W  : MAC channel 2 result.
- mac_done  in  1  : MAC result valid, single-cycle pulse.
- res_valid  out  1  : result available.
- res_ready  in  1  : downstream accepts the result.
- res0  out  ACC_W  : captured channel 1 result.
- res1  out  ACC_W  : captured channel 2 result.
- err  out  1  : sticky watchdog error.

Behaviour:
- Reset: state IDLE; all outputs 0 (busy, rd_en, rd_addr, mac_clr, mac_vld, mac_in, res_valid, res0, res1, err). Reset mid-frame returns immediately to IDLE; no partial result is produced.
- States: IDLE, CLR, FEED, DRAIN, WAIT, HOLD.
- IDLE: start=1 -> CLR. start=1 also clears err.
- CLR: mac_clr=1 for exactly one cycle -> FEED.
- FEED:
  - rd_en=1 each cycle; rd_addr steps 0..BEATS-1 by 1.
  - After the beat at BEATS-1 -> DRAIN.
  - rd_addr returns to 0 on leaving FEED. It never wraps inside FEED.
- Pipeline: mac_vld is rd_en delayed one cycle, and mac_in = rd_data in that same cycle. mac_in is held at 0 when mac_vld=0.
- DRAIN: one cycle to present the last beat (mac_vld=1, rd_en=0) -> WAIT.
- WAIT:
  - Watchdog counter starts at 0 and increments each cycle.
  - mac_done=1: res0/res1 <= mac_out0/mac_out1 -> HOLD.
  - Counter reaches WD_CYC with no mac_done: err=1 -> IDLE, and res_valid stays 0.
- HOLD:
  - res_valid=1; res0/res1 stable until the handshake.
  - res_valid & res_ready -> IDLE, with res_valid=0 the next cycle.
  - start is ignored in HOLD, including when it coincides with res_ready; it must be reissued in IDLE.
- Timing, with start sampled at cycle 0:
  - mac_clr is high in cycle 1.
  - rd_en is high in cycles 2..BEATS+1.
  - mac_vld is high in cycles 3..BEATS+2 (3..38 by default).
  - WAIT is entered at cycle BEATS+3.
  - mac_done in WAIT at cycle k makes res_valid rise at k+1.
- Spurious mac_done outside WAIT is ignored and does not affect state or results.
- abort=1 in any non-IDLE state -> IDLE next cycle. rd_en, mac_vld and res_valid drop; the in-flight beat is discarded; err is unchanged. abort has priority over start, mac_done and res_ready.
- Data is passed through unmodified; the controller does no arithmetic on features or results.

Test Plan:
- Nominal frame: buffer beat i = {2'd1,2'd2,2'd3}; start at cycle 0; MAC model pulses mac_done 2 cycles after the last mac_vld with mac_out0=10'h3B8, mac_out1=10'h394.
  -> mac_clr in cycle 1 only; exactly 36 mac_vld beats in cycles 3..38, each with mac_in = {1,2,3}.
  -> res_valid=1 with res0=10'h3B8, res1=10'h394; rd_addr sequence 0..35 with no gaps.
- Backpressure: hold res_ready=0 for 10 cycles in HOLD.
  -> res_valid/res0/res1 stable; a start pulsed during HOLD is ignored.
  -> Releasing res_ready returns to IDLE; busy=0 the next cycle.
- Watchdog: mac_done never asserted.
  -> err=1 exactly WD_CYC cycles after entering WAIT; res_valid stays 0; state returns to IDLE.
  -> The next start clears err and a normal frame completes.
- Abort mid-FEED (rd_addr=17).
  -> Next cycle: busy=0, rd_en=0, mac_vld=0, no res_valid.
  -> The following start restarts from rd_addr 0 with mac_clr.
- Async reset asserted in WAIT for 1 ns between edges.
  -> All outputs go to 0 immediately; no result is produced after release.
- Spurious mac_done during FEED.
  -> Ignored: the full 36 beats still stream, and the later real mac_done is the one captured.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Frame sequencer for the VAD binary-weight MAC: clear, stream feature beats,
// wait for mac_done under a watchdog, then hold both results on valid/ready.
module mac_seq_ctrl #(
    parameter int N_ELEM = 108,
    parameter int LANES  = 3,
    parameter int DW     = 2,
    parameter int ADDR_W = 6,
    parameter int ACC_W  = 10,
    parameter int WD_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [LANES*DW-1:0]   rd_data,
    output logic                  mac_clr,
    output logic                  mac_vld,
    output logic [LANES*DW-1:0]   mac_in,
    input  logic [ACC_W-1:0]      mac_out0,
    input  logic [ACC_W-1:0]      mac_out1,
    input  logic                  mac_done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_W-1:0]      res0,
    output logic [ACC_W-1:0]      res1,
    output logic                  err
);

    localparam int BEATS = N_ELEM / LANES;
    localparam int WD_W  = $clog2(WD_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BEATS - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_mac_vld;
    logic [WD_W-1:0]     r_wd;
    logic [ACC_W-1:0]    r_res0;
    logic [ACC_W-1:0]    r_res1;
    logic                r_err;
    logic                w_wd_expire;

    // NOTE: next state gets its default before the case, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CLR;
            S_CLR:   w_next = S_FEED;
            S_FEED:  if (r_addr == LAST_BEAT) w_next = S_DRAIN;
            S_DRAIN: w_next = S_WAIT;
            S_WAIT: begin
                if (mac_done)              w_next = S_HOLD;
                else if (r_wd == WD_LAST)  w_next = S_IDLE;
            end
            S_HOLD:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    assign w_wd_expire = (r_state == S_WAIT) && !mac_done && (r_wd == WD_LAST) && !abort;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_mac_vld <= 1'b0;
            r_wd      <= '0;
            r_res0    <= '0;
            r_res1    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_addr    <= (r_state == S_FEED && w_next == S_FEED) ? r_addr + ADDR_W'(1) : '0;
            // An aborted read never reaches the MAC.
            r_mac_vld <= (r_state == S_FEED) && !abort;
            r_wd      <= (r_state == S_WAIT && w_next == S_WAIT) ? r_wd + WD_W'(1) : '0;
            if (r_state == S_WAIT && w_next == S_HOLD) begin
                r_res0 <= mac_out0;
                r_res1 <= mac_out1;
            end
            if (r_state == S_IDLE && w_next == S_CLR) begin
                r_err <= 1'b0;
            end else if (w_wd_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign rd_en     = (r_state == S_FEED);
    assign rd_addr   = r_addr;
    assign mac_clr   = (r_state == S_CLR);
    assign mac_vld   = r_mac_vld;
    assign mac_in    = r_mac_vld ? rd_data : '0;
    assign res_valid = (r_state == S_HOLD);
    assign res0      = r_res0;
    assign res1      = r_res1;
    assign err       = r_err;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: a per-cycle snapshot log of one frame is
// compared against a hand-written vector table, plus multi-cycle corner sequences.
module tb_mac_seq_ctrl;

    localparam int BEATS  = 36;
    localparam int ADDR_W = 6;
    localparam int ACC_W  = 10;
    localparam int LW     = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              res_ready = 1'b0;
    logic              spur_done = 1'b0;
    logic              model_done = 1'b0;
    logic              model_arm = 1'b0;
    logic              data_mode = 1'b0;
    logic              busy, rd_en, mac_clr, mac_vld, res_valid, err, mac_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [LW-1:0]     rd_data = '0;
    logic [LW-1:0]     mac_in;
    logic [ACC_W-1:0]  mac_out0 = '0;
    logic [ACC_W-1:0]  mac_out1 = '0;
    logic [ACC_W-1:0]  res0, res1;

    int cyc = 0;
    int c0 = 0;
    int vld_cnt = 0;
    int done_at = -1;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic              busy;
        logic              rd_en;
        logic              mac_clr;
        logic              mac_vld;
        logic              res_valid;
        logic              err;
        logic [ADDR_W-1:0] rd_addr;
        logic [LW-1:0]     mac_in;
        logic [ACC_W-1:0]  res0;
        logic [ACC_W-1:0]  res1;
    } snap_t;

    typedef struct {
        int                rel;
        logic              busy;
        logic              rd_en;
        logic              mac_clr;
        logic              mac_vld;
        logic              res_valid;
        logic [ADDR_W-1:0] rd_addr;
        logic [LW-1:0]     mac_in;
    } vec_t;

    snap_t snap [0:127];
    vec_t  vecs [13];

    assign mac_done = model_done | spur_done;

    mac_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .mac_clr   (mac_clr),
        .mac_vld   (mac_vld),
        .mac_in    (mac_in),
        .mac_out0  (mac_out0),
        .mac_out1  (mac_out1),
        .mac_done  (mac_done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res0      (res0),
        .res1      (res1),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered feature buffer; garbage when not read so mac_in gating is visible.
    always @(posedge clk) rd_data <= rd_en ? (data_mode ? LW'(rd_addr) : 6'h1B) : 6'h2A;

    // MAC model: pulse mac_done two cycles after the 36th mac_vld of a frame.
    always @(negedge clk) begin
        model_done = model_arm && (done_at == cyc);
        if (mac_clr) begin
            vld_cnt = 0;
        end else if (mac_vld) begin
            vld_cnt = vld_cnt + 1;
            if (vld_cnt == BEATS) done_at = cyc + 2;
        end
    end

    always @(negedge clk) begin
        int    rel;
        snap_t s;
        rel = cyc - c0;
        s.busy = busy; s.rd_en = rd_en; s.mac_clr = mac_clr; s.mac_vld = mac_vld;
        s.res_valid = res_valid; s.err = err; s.rd_addr = rd_addr; s.mac_in = mac_in;
        s.res0 = res0; s.res1 = res1;
        if (rel >= 0 && rel < 128) snap[rel] = s;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rel(input int r);
        while (cyc - c0 < r) @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic int count_vld(input int a, input int b);
        int n = 0;
        for (int r = a; r <= b; r++) if (snap[r].mac_vld) n++;
        return n;
    endfunction

    function automatic int count_clr(input int a, input int b);
        int n = 0;
        for (int r = a; r <= b; r++) if (snap[r].mac_clr) n++;
        return n;
    endfunction

    function automatic int count_rv(input int a, input int b);
        int n = 0;
        for (int r = a; r <= b; r++) if (snap[r].res_valid) n++;
        return n;
    endfunction

    function automatic int count_busy(input int a, input int b);
        int n = 0;
        for (int r = a; r <= b; r++) if (snap[r].busy) n++;
        return n;
    endfunction

    // Beats at rel 3..38 carry addr rel-3; mode 0 is constant {1,2,3}.
    function automatic int bad_stream(input int last, input logic mode);
        int n = 0;
        for (int r = 1; r <= last; r++) begin
            logic          in_vld;
            logic [LW-1:0] exp_in;
            in_vld = (r >= 3 && r <= 38);
            exp_in = in_vld ? (mode ? LW'(r - 3) : 6'h1B) : 6'h00;
            if (snap[r].mac_vld !== in_vld || snap[r].mac_in !== exp_in) n++;
            if (r >= 2 && r <= 37 && (snap[r].rd_en !== 1'b1 || snap[r].rd_addr !== ADDR_W'(r - 2))) n++;
        end
        return n;
    endfunction

    initial begin
        vecs[0]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  6'h00};
        vecs[1]  = '{2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'h00};
        vecs[2]  = '{3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1,  6'h1B};
        vecs[3]  = '{19, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd17, 6'h1B};
        vecs[4]  = '{37, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd35, 6'h1B};
        vecs[5]  = '{38, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'h1B};
        vecs[6]  = '{39, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'h00};
        vecs[7]  = '{40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'h00};
        vecs[8]  = '{41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  6'h00};
        vecs[9]  = '{46, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  6'h00};
        vecs[10] = '{51, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  6'h00};
        vecs[11] = '{52, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'h00};
        vecs[12] = '{53, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'h00};

        repeat (3) @(negedge clk);
        check("reset outputs", 64'({busy, rd_en, rd_addr, mac_clr, mac_vld, mac_in, res_valid, res0, res1, err}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal frame with 10 cycles of backpressure and a start during HOLD.
        data_mode = 1'b0; model_arm = 1'b1; res_ready = 1'b0;
        mac_out0 = 10'h3B8; mac_out1 = 10'h394;
        start_frame();
        wait_rel(45); start = 1'b1; @(negedge clk); start = 1'b0;
        wait_rel(51); res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
        wait_rel(58);
        for (int i = 0; i < 13; i++) begin
            snap_t s;
            s = snap[vecs[i].rel];
            check($sformatf("vec rel=%0d", vecs[i].rel),
                  64'({s.busy, s.rd_en, s.mac_clr, s.mac_vld, s.res_valid, s.rd_addr, s.mac_in}),
                  64'({vecs[i].busy, vecs[i].rd_en, vecs[i].mac_clr, vecs[i].mac_vld,
                       vecs[i].res_valid, vecs[i].rd_addr, vecs[i].mac_in}));
        end
        check("nominal mac_clr count", 64'(count_clr(1, 57)), 64'(1));
        check("nominal mac_vld count", 64'(count_vld(1, 57)), 64'(BEATS));
        check("nominal stream errors", 64'(bad_stream(57, 1'b0)), 64'(0));
        begin
            int n = 0;
            for (int r = 41; r <= 51; r++)
                if (!snap[r].res_valid || snap[r].res0 !== 10'h3B8 || snap[r].res1 !== 10'h394) n++;
            check("hold result unstable cycles", 64'(n), 64'(0));
        end
        check("busy after release", 64'(count_busy(52, 57)), 64'(0));

        // Abort mid-FEED at rd_addr 17, then a clean restart.
        data_mode = 1'b1; res_ready = 1'b1;
        mac_out0 = 10'h155; mac_out1 = 10'h2AA;
        start_frame();
        wait_rel(19);
        check("addr at abort", 64'(rd_addr), 64'(17));
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("after abort busy/rd_en/vld/rv", 64'({busy, rd_en, mac_vld, res_valid}), 64'(0));
        wait_rel(50);
        check("abort no result", 64'(count_rv(20, 49)), 64'(0));
        check("abort busy cycles", 64'(count_busy(20, 49)), 64'(0));
        check("abort vld count", 64'(count_vld(1, 49)), 64'(17));
        check("abort err unchanged", 64'(snap[30].err), 64'(0));
        start_frame();
        wait_rel(46);
        check("restart clr", 64'({snap[1].mac_clr, snap[2].rd_en, snap[2].rd_addr}), 64'({1'b1, 1'b1, 6'd0}));
        check("restart stream errors", 64'(bad_stream(45, 1'b1)), 64'(0));
        check("restart result", 64'({snap[41].res_valid, snap[41].res0, snap[41].res1}), 64'({1'b1, 10'h155, 10'h2AA}));
        check("restart idle after handshake", 64'({snap[42].busy, snap[42].res_valid}), 64'(0));

        // Watchdog: no mac_done at all; WAIT entered at rel 39.
        model_arm = 1'b0; data_mode = 1'b0;
        start_frame();
        wait_rel(62);
        check("wd last wait cycle busy/err/rv", 64'({snap[54].busy, snap[54].err, snap[54].res_valid}), 64'(3'b100));
        check("wd expire busy/err/rv", 64'({snap[55].busy, snap[55].err, snap[55].res_valid}), 64'(3'b010));
        check("wd no result", 64'(count_rv(1, 61)), 64'(0));
        check("wd err sticky", 64'(snap[61].err), 64'(1));

        // Next start clears err; mac_done on the last allowed WAIT cycle is accepted.
        mac_out0 = 10'h0AB; mac_out1 = 10'h3C0;
        start_frame();
        wait_rel(54); spur_done = 1'b1; @(negedge clk); spur_done = 0;
        wait_rel(60);
        check("err cleared by start", 64'(snap[1].err), 64'(0));
        check("late done result", 64'({snap[55].res_valid, snap[55].err, snap[55].res0, snap[55].res1}),
              64'({1'b1, 1'b0, 10'h0AB, 10'h3C0}));
        check("late done idle", 64'(snap[56].busy), 64'(0));

        // Asynchronous reset pulse in WAIT.
        start_frame();
        wait_rel(42);
        #1 rst_n = 1'b0;
        #1;
        check("async reset outputs", 64'({busy, rd_en, rd_addr, mac_clr, mac_vld, mac_in, res_valid, res0, res1, err}), 64'(0));
        rst_n = 1'b1;
        wait_rel(65);
        check("post reset no result", 64'(count_rv(43, 64)), 64'(0));
        check("post reset busy", 64'(count_busy(43, 64)), 64'(0));

        // Spurious mac_done during FEED, then a real one from the model.
        model_arm = 1'b1;
        mac_out0 = 10'h111; mac_out1 = 10'h222;
        start_frame();
        wait_rel(10); spur_done = 1'b1; @(negedge clk); spur_done = 1'b0;
        wait_rel(30);
        mac_out0 = 10'h2C5; mac_out1 = 10'h13A;
        wait_rel(46);
        spur_done = 1'b1; @(negedge clk); spur_done = 1'b0;
        wait_rel(50);
        check("spurious vld count", 64'(count_vld(1, 45)), 64'(BEATS));
        check("spurious stream errors", 64'(bad_stream(45, 1'b0)), 64'(0));
        check("spurious result", 64'({snap[41].res_valid, snap[41].res0, snap[41].res1}), 64'({1'b1, 10'h2C5, 10'h13A}));
        check("idle done ignored", 64'({snap[49].busy, snap[49].res_valid, snap[49].res0}), 64'({1'b0, 1'b0, 10'h2C5}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
